// File: rtl/btn_debounce_pkg.sv
// ============================================================================
// btn_debounce_pkg : shared defaults and helpers for the push-button conditioner
// Revision: 1.0
// ============================================================================
`default_nettype none

package btn_debounce_pkg;

   // 10 ms at 50 MHz
   localparam int unsigned BTN_DEBOUNCE_CYCLES = 500000;
   localparam logic        BTN_PRESSED_LEVEL   = 1'b0;

   function automatic logic is_pressed(input logic sample, input logic pressed_level);
      return (sample == pressed_level);
   endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce_if.sv
// ============================================================================
// btn_debounce_if : pad/bus side signals of the push-button conditioner
// Revision: 1.0
// ============================================================================
`default_nettype none

interface btn_debounce_if;

   logic btn_raw;
   logic btn_ren;
   logic btn_out;
   logic btn_level;
   logic press_pulse;

   modport master (
      output btn_raw,
      output btn_ren,
      input  btn_out,
      input  btn_level,
      input  press_pulse
   );

   modport slave (
      input  btn_raw,
      input  btn_ren,
      output btn_out,
      output btn_level,
      output press_pulse
   );

endinterface

`default_nettype wire

// File: rtl/btn_debounce_sync_2ff.sv
// ============================================================================
// sync_2ff : 1-bit two-flop synchroniser with configurable reset value
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic d_i,
   output logic      q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce : synchronise, debounce and optionally latch a board push-button
// Optional feature macro: BTN_STICKY_EN (hold a press until the CPU reads it)
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
   parameter logic        PRESSED_LEVEL   = BTN_PRESSED_LEVEL
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   btn_debounce_if.slave  bus
);

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      WAIT_PRESS   = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;
   logic             out_q, out_d;
   logic             raw_sync;
   logic             pressed_s;

   sync_2ff #(
      .RESET_VAL (~PRESSED_LEVEL)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bus.btn_raw),
      .q_o   (raw_sync)
   );

   assign pressed_s = is_pressed(raw_sync, PRESSED_LEVEL);

   // The counter only advances below CNT_MAX, so it saturates instead of wrapping
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RELEASED: begin
            if (pressed_s) begin
               state_d = WAIT_PRESS;
               cnt_d   = '0;
            end
         end
         WAIT_PRESS: begin
            if (!pressed_s) begin
               state_d = RELEASED;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!pressed_s) begin
               state_d = WAIT_RELEASE;
               cnt_d   = '0;
            end
         end
         WAIT_RELEASE: begin
            if (pressed_s) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_MAX) begin
               state_d = RELEASED;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
      level_d = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
      pulse_d = (state_q == WAIT_PRESS) && (state_d == PRESSED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         out_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         out_q   <= out_d;
      end
   end

`ifdef BTN_STICKY_EN
   logic ren_q;
   logic latch_q, latch_d;
   logic rd_edge;

   // A press and a read landing together keep the latch set so no tap is lost
   always_comb begin
      rd_edge = bus.btn_ren & ~ren_q;
      latch_d = latch_q;
      if (pulse_q) begin
         latch_d = 1'b1;
      end else if (rd_edge) begin
         latch_d = 1'b0;
      end
      out_d = ~(latch_q | level_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ren_q   <= 1'b0;
         latch_q <= 1'b0;
      end else begin
         ren_q   <= bus.btn_ren;
         latch_q <= latch_d;
      end
   end
`else
   logic unused_ren;

   assign unused_ren = bus.btn_ren;

   always_comb begin
      out_d = ~level_q;
   end
`endif

   assign bus.btn_out     = out_q;
   assign bus.btn_level   = level_q;
   assign bus.press_pulse = pulse_q;

endmodule

`default_nettype wire
